// File: rtl/program_counter.sv
// Program counter for the picoMIPS core: steps to the next address or loads an absolute
// branch target every clock, with an asynchronous active-high clear to address zero.
module program_counter #(
    parameter int unsigned Psize = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCincr,
    input  logic [Psize-1:0] Branchaddr,
    output logic [Psize-1:0] PCout
);

    localparam logic [Psize-1:0] PcOne = {{(Psize-1){1'b0}}, 1'b1};

    logic [Psize-1:0] pc_q;
    logic [Psize-1:0] pc_d;

    // Increment wraps naturally at 2^Psize; a branch is an absolute load.
    always_comb begin
        pc_d = pc_q;
        if (PCincr) begin
            pc_d = pc_q + PcOne;
        end else begin
            pc_d = Branchaddr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PCout = pc_q;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: directed test plan followed by random
// increment/branch/reset traffic checked against an arithmetic reference model.
module tb_program_counter;

    localparam int unsigned Psize = 6;
    localparam int unsigned Span  = 64;

    logic             clk;
    logic             reset;
    logic             PCincr;
    logic [Psize-1:0] Branchaddr;
    logic [Psize-1:0] PCout;

    int total;
    int bad;
    int model_pc;

    program_counter #(
        .Psize(Psize)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .PCincr    (PCincr),
        .Branchaddr(Branchaddr),
        .PCout     (PCout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs, advance the model, then check one unit after the edge.
    task automatic step(input logic inc, input logic [Psize-1:0] br, input logic rst,
                        input string tag);
        PCincr     = inc;
        Branchaddr = br;
        reset      = rst;
        if (rst) model_pc = 0;
        else if (inc) model_pc = (model_pc + 1) % Span;
        else model_pc = int'(br);
        @(posedge clk);
        #1;
        check(tag, {26'b0, PCout}, model_pc);
    endtask

    // Assert reset between edges and confirm the clear needs no clock.
    task automatic mid_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        model_pc = 0;
        check(tag, {26'b0, PCout}, 32'd0);
    endtask

    initial begin
        logic [Psize-1:0] rb;
        int               r;
        total      = 0;
        bad        = 0;
        model_pc   = 0;
        reset      = 1'b0;
        PCincr     = 1'b1;
        Branchaddr = 6'd12;

        // Asynchronous clear before the first clock edge.
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", {26'b0, PCout}, 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 6'd12, 1'b1, "reset_hold");

        for (int i = 0; i < 5; i++) step(1'b1, 6'd12, 1'b0, "count");
        check("count_end", {26'b0, PCout}, 32'd5);

        step(1'b0, 6'b001100, 1'b0, "branch");
        step(1'b1, 6'd0, 1'b0, "branch_inc");
        step(1'b1, 6'd0, 1'b0, "branch_inc");

        step(1'b0, 6'd62, 1'b0, "wrap_load");
        step(1'b1, 6'd0, 1'b0, "wrap_63");
        step(1'b1, 6'd0, 1'b0, "wrap_0");
        step(1'b1, 6'd0, 1'b0, "wrap_1");

        step(1'b1, 6'd0, 1'b1, "pre_mid_reset");
        for (int i = 0; i < 3; i++) step(1'b1, 6'd0, 1'b0, "count_to_3");
        mid_reset("mid_reset");
        step(1'b1, 6'd0, 1'b0, "after_mid_reset");

        for (int i = 0; i < 4; i++) step(1'b0, 6'd7, 1'b0, "halt_loop");

        // Random traffic: mostly increments, some branches, halts and resets.
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            rb = Psize'($urandom);
            if (r < 4) begin
                step(1'($urandom), rb, 1'b1, "rand_reset");
            end else if (r < 8) begin
                mid_reset("rand_mid_reset");
                step(1'b1, rb, 1'b0, "rand_release");
            end else if (r < 70) begin
                step(1'b1, rb, 1'b0, "rand_inc");
            end else if (r < 80) begin
                step(1'b0, model_pc[Psize-1:0], 1'b0, "rand_halt");
            end else begin
                step(1'b0, rb, 1'b0, "rand_branch");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
